// File: rtl/mips_pkg.sv
// mips_pkg: shared encodings for the multicycle MIPS control path
package mips_pkg;
  typedef enum logic [3:0] {
    RST_WAIT = 4'd0,
    FETCH    = 4'd1,
    DECODE   = 4'd2,
    MEM_ADDR = 4'd3,
    MEM_RD   = 4'd4,
    MEM_WB   = 4'd5,
    MEM_WR   = 4'd6,
    R_EXEC   = 4'd7,
    R_WB     = 4'd8,
    BRANCH   = 4'd9,
    JUMP     = 4'd10
  } state_t;
  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_J   = 6'b000010;
  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;
  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;
  function automatic logic is_legal(input logic [5:0] o);
    return o == OP_R || o == OP_LW || o == OP_SW || o == OP_BEQ || o == OP_J;
  endfunction
endpackage

// File: rtl/multicycle_control.sv
// multicycle_control: multicycle MIPS main control FSM
module multicycle_control
  import mips_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_en,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic       instr_done,
  output logic       illegal_op,
  output logic [3:0] state
);
  state_t state_q, state_d;
  assign state = state_q;
  // state register; reset drops straight into RST_WAIT, aborting any access
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= RST_WAIT;
    else state_q <= state_d;
  // next state and per-state outputs; only memory and branch strobes look at inputs
  always_comb begin
    state_d    = state_q;
    pc_en      = 1'b0;
    i_or_d     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    mem_to_reg = 1'b0;
    reg_dst    = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_REG;
    alu_op     = ALU_ADD;
    pc_source  = PC_ALU;
    instr_done = 1'b0;
    illegal_op = 1'b0;
    case (state_q)
      RST_WAIT: state_d = FETCH;
      FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        ir_write  = mem_ready;
        pc_en     = mem_ready;
        state_d   = mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        alu_src_b  = SRCB_IMM_SH;
        illegal_op = !is_legal(op);
        instr_done = !is_legal(op);
        state_d    = (op == OP_LW || op == OP_SW) ? MEM_ADDR :
                     op == OP_R   ? R_EXEC :
                     op == OP_BEQ ? BRANCH :
                     op == OP_J   ? JUMP : FETCH;
      end
      MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        state_d   = op == OP_LW ? MEM_RD : MEM_WR;
      end
      MEM_RD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        state_d  = mem_ready ? MEM_WB : MEM_RD;
      end
      MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
        state_d    = FETCH;
      end
      MEM_WR: begin
        mem_write  = 1'b1;
        i_or_d     = 1'b1;
        instr_done = mem_ready;
        state_d    = mem_ready ? FETCH : MEM_WR;
      end
      R_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_FUNCT;
        state_d   = R_WB;
      end
      R_WB: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        instr_done = 1'b1;
        state_d    = FETCH;
      end
      BRANCH: begin
        alu_src_a  = 1'b1;
        alu_op     = ALU_SUB;
        pc_source  = PC_ALUOUT;
        pc_en      = zero;
        instr_done = 1'b1;
        state_d    = FETCH;
      end
      JUMP: begin
        pc_source  = PC_JUMP;
        pc_en      = 1'b1;
        instr_done = 1'b1;
        state_d    = FETCH;
      end
      default: state_d = FETCH;
    endcase
  end
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: per-cycle reference check, latency table and corner sequences
module tb_multicycle_control;
  logic clk = 1'b0, rst_n = 1'b0, zero = 1'b0, mem_ready = 1'b1;
  logic [5:0] op = 6'd0;
  logic pc_en, i_or_d, mem_read, mem_write, ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic instr_done, illegal_op;
  logic [3:0] state;
  int vectors = 0, errors = 0, rd_cnt = 0, irw_cnt = 0;
  string plan = "FD";
  int idx = 0;
  bit rw = 1'b1, last_done = 1'b0;
  typedef struct {logic [5:0] op; logic zero; int waits; int lat;} vec_t;
  vec_t tbl[11];
  multicycle_control dut (
    .clk(clk), .rst_n(rst_n), .op(op), .zero(zero), .mem_ready(mem_ready),
    .pc_en(pc_en), .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_source(pc_source),
    .instr_done(instr_done), .illegal_op(illegal_op), .state(state)
  );
  always #5 clk = ~clk;
  // Step letters per instruction: F fetch, D decode, A address, R read, W writeback, S store, E exec, X reg write, B branch, J jump
  function automatic string plan_for(input logic [5:0] o);
    case (o)
      6'b100011: return "FDARW";
      6'b101011: return "FDAS";
      6'b000000: return "FDEX";
      6'b000100: return "FDB";
      6'b000010: return "FDJ";
      default:   return "FD";
    endcase
  endfunction
  function automatic logic [20:0] expect_out(input byte s, input logic [5:0] o, input logic mr, input logic z);
    logic pe, iod, mrd, mwr, irw, m2r, rdst, regw, sa, dn, il;
    logic [1:0] sb, ao, ps;
    logic [3:0] st;
    {pe, iod, mrd, mwr, irw, m2r, rdst, regw, sa, dn, il} = '0;
    {sb, ao, ps, st} = '0;
    case (s)
      "F": begin st = 4'd1; mrd = 1; sb = 2'b01; irw = mr; pe = mr; end
      "D": begin st = 4'd2; sb = 2'b11; il = plan_for(o) == "FD"; dn = il; end
      "A": begin st = 4'd3; sa = 1; sb = 2'b10; end
      "R": begin st = 4'd4; mrd = 1; iod = 1; end
      "W": begin st = 4'd5; regw = 1; m2r = 1; dn = 1; end
      "S": begin st = 4'd6; mwr = 1; iod = 1; dn = mr; end
      "E": begin st = 4'd7; sa = 1; ao = 2'b10; end
      "X": begin st = 4'd8; regw = 1; rdst = 1; dn = 1; end
      "B": begin st = 4'd9; sa = 1; ao = 2'b01; ps = 2'b01; pe = z; dn = 1; end
      "J": begin st = 4'd10; ps = 2'b10; pe = 1; dn = 1; end
      default: st = 4'd0;
    endcase
    return {pe, iod, mrd, mwr, irw, m2r, rdst, regw, sa, sb, ao, ps, dn, il, st};
  endfunction
  function automatic byte cur_step();
    return (rw || !rst_n) ? "0" : plan[idx];
  endfunction
  task automatic tick();
    byte s;
    logic [20:0] e, a;
    bit adv;
    s = cur_step();
    @(negedge clk);
    e = expect_out(s, op, mem_ready, zero);
    a = {pc_en, i_or_d, mem_read, mem_write, ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a,
         alu_src_b, alu_op, pc_source, instr_done, illegal_op, state};
    vectors++;
    if (a !== e) begin
      errors++;
      $display("FAIL outputs step=%s op=%b mr=%b z=%b got=%h want=%h", s, op, mem_ready, zero, a, e);
    end
    rd_cnt += int'(mem_read);
    irw_cnt += int'(ir_write);
    last_done = instr_done;
    adv = !(s == "F" || s == "R" || s == "S") || mem_ready;
    if (!rst_n) begin rw = 1; plan = "FD"; idx = 0; end
    else if (rw) begin rw = 0; plan = "FD"; idx = 0; end
    else if (adv) begin
      if (s == "D") plan = plan_for(op);
      if (idx == plan.len() - 1) begin plan = "FD"; idx = 0; end
      else idx++;
    end
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string name, input int got, input int want);
    vectors++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask
  initial begin
    int n, wc, waits;
    byte s, prev;
    logic [5:0] ops[5] = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b000010};
    tbl[0]  = '{6'b100011, 1'b0, 0, 5};
    tbl[1]  = '{6'b000100, 1'b0, 0, 3};
    tbl[2]  = '{6'b000100, 1'b1, 0, 3};
    tbl[3]  = '{6'b111111, 1'b0, 0, 2};
    tbl[4]  = '{6'b000000, 1'b0, 0, 4};
    tbl[5]  = '{6'b000010, 1'b0, 0, 3};
    tbl[6]  = '{6'b101011, 1'b0, 0, 4};
    tbl[7]  = '{6'b100011, 1'b0, 2, 9};
    tbl[8]  = '{6'b101011, 1'b1, 1, 6};
    tbl[9]  = '{6'b000000, 1'b0, 3, 7};
    tbl[10] = '{6'b010101, 1'b1, 1, 3};
    op = 6'b100011;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 11; i++) begin
      op = tbl[i].op;
      zero = tbl[i].zero;
      n = 0; wc = 0; prev = " "; last_done = 0;
      while (!last_done && n < 40) begin
        s = cur_step();
        wc = (s == prev) ? wc + 1 : 0;
        prev = s;
        mem_ready = (s == "F" || s == "R" || s == "S") ? (wc >= tbl[i].waits) : 1'b1;
        tick();
        n++;
      end
      check($sformatf("latency[%0d]", i), n, tbl[i].lat);
    end
    rd_cnt = 0; irw_cnt = 0; op = 6'b000010;
    for (int i = 0; i < 4; i++) begin mem_ready = (i == 3); tick(); end
    check("fetch_mem_read_cycles", rd_cnt, 4);
    check("fetch_ir_write_cycles", irw_cnt, 1);
    mem_ready = 1'b1;
    tick();
    tick();
    op = 6'b101011; mem_ready = 1'b1;
    n = 0;
    while (cur_step() != "S" && n < 20) begin mem_ready = cur_step() == "F"; tick(); n++; end
    mem_ready = 1'b0;
    tick();
    #2 rst_n = 1'b0;
    #1;
    check("reset_mem_write", int'(mem_write), 0);
    check("reset_state", int'(state), 0);
    rw = 1;
    @(posedge clk); #1;
    tick();
    rst_n = 1'b1;
    tick();
    check("first_fetch_after_reset", int'(state), 1);
    for (int c = 0; c < 600; c++) begin
      if (!rw && idx == 0)
        op = ($urandom_range(0, 5) == 0) ? 6'($urandom) : ops[$urandom_range(0, 4)];
      mem_ready = $urandom_range(0, 3) != 0;
      zero = 1'($urandom);
      tick();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; the port list SHALL be as in REQ-002..REQ-021, clock and reset first.
REQ-002 clk  in  1  sole clock; all state changes on the rising edge.
REQ-003 rst_n  in  1  asynchronous active-low reset.
REQ-004 op  in  6  instruction opcode field from the instruction register.
REQ-005 zero  in  1  ALU zero flag.
REQ-006 mem_ready  in  1  memory handshake; access completes in the cycle it is 1.
REQ-007 pc_en  out  1  PC load enable, already qualified by the branch condition.
REQ-008 i_or_d  out  1  memory address select: 0 = PC, 1 = ALU out.
REQ-009 mem_read  out  1  memory read strobe.
REQ-010 mem_write  out  1  memory write strobe.
REQ-011 ir_write  out  1  instruction register load.
REQ-012 mem_to_reg  out  1  writeback data select: 1 = MDR.
REQ-013 reg_dst  out  1  destination select: 1 = rd, 0 = rt.
REQ-014 reg_write  out  1  register file write.
REQ-015 alu_src_a  out  1  0 = PC, 1 = register A.
REQ-016 alu_src_b  out  2  00 = B, 01 = constant 4, 10 = sign-extended imm, 11 = imm << 2.
REQ-017 alu_op  out  2  to the ALU function decoder: 00 add, 01 subtract, 10 use funct.
REQ-018 pc_source  out  2  00 = ALU result, 01 = ALU out register, 10 = jump target.
REQ-019 instr_done  out  1  one-cycle pulse in an instruction's final cycle.
REQ-020 illegal_op  out  1  one-cycle pulse on an unsupported opcode.
REQ-021 state  out  4  current state encoding, for debug.

Function
REQ-022 States: RST_WAIT, FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, R_EXEC, R_WB, BRANCH, JUMP.
REQ-023 Opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, j 000010; any other opcode is illegal.
REQ-024 RST_WAIT SHALL drive every output to 0 and go to FETCH on the next edge.
REQ-025 FETCH SHALL hold mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01 and alu_op=00 until mem_ready=1; in that cycle only, ir_write=1 and pc_en=1 with pc_source=00, then go to DECODE.
REQ-026 DECODE SHALL drive alu_src_a=0, alu_src_b=11 and alu_op=00; next state by op: lw/sw go to MEM_ADDR, R-type to R_EXEC, beq to BRANCH, j to JUMP.
REQ-027 On an illegal op, DECODE SHALL pulse illegal_op=1 and instr_done=1 and return to FETCH.
REQ-028 MEM_ADDR SHALL drive alu_src_a=1, alu_src_b=10 and alu_op=00; lw goes to MEM_RD, sw to MEM_WR.
REQ-029 MEM_RD SHALL hold mem_read=1 and i_or_d=1 until mem_ready=1, then go to MEM_WB.
REQ-030 MEM_WB SHALL drive reg_write=1, mem_to_reg=1, reg_dst=0 and instr_done=1, then go to FETCH.
REQ-031 MEM_WR SHALL hold mem_write=1 and i_or_d=1 until mem_ready=1; instr_done=1 in that cycle, then go to FETCH.
REQ-032 R_EXEC SHALL drive alu_src_a=1, alu_src_b=00 and alu_op=10, then go to R_WB.
REQ-033 R_WB SHALL drive reg_write=1, reg_dst=1, mem_to_reg=0 and instr_done=1, then go to FETCH.
REQ-034 BRANCH SHALL drive alu_src_a=1, alu_src_b=00, alu_op=01, pc_source=01, pc_en=zero and instr_done=1, then go to FETCH.
REQ-035 JUMP SHALL drive pc_source=10, pc_en=1 and instr_done=1, then go to FETCH.
REQ-036 Any output not listed for a state SHALL be 0; only the mem_ready- and zero-qualified strobes are Mealy, all others are decoded from the state register.
REQ-037 Zero-wait latencies SHALL be: j and beq 3 cycles, R-type and sw 4, lw 5; each mem_ready=0 cycle adds one cycle.
REQ-038 An unreachable state encoding SHALL go to FETCH on the next edge with all outputs 0.

Reset
REQ-039 Asserting rst_n=0 SHALL force RST_WAIT and all outputs to 0 immediately, including mid-access, without waiting for mem_ready.
REQ-040 After rst_n rises, the first FETCH SHALL begin exactly one edge later.

Structure
REQ-041 The state encodings, opcode constants, and alu_op, alu_src_b and pc_source encodings SHALL live in the shared package mips_pkg.
REQ-042 There SHALL be no sub-module; the ALU function decoder is instantiated beside this block and driven by alu_op.

Verification
REQ-043 Release reset with mem_ready=1 and op=100011 -> states 1,2,3,4,5 after RST_WAIT; instr_done at cycle 5; reg_write=1 with mem_to_reg=1.
REQ-044 beq with zero=0, then beq with zero=1 -> pc_en=0 then 1 in BRANCH, alu_op=01 both times.
REQ-045 FETCH with mem_ready low for 3 cycles -> mem_read held 4 cycles; ir_write and pc_en exactly 1 cycle.
REQ-046 op=111111 -> illegal_op and instr_done pulse in DECODE; next state FETCH; reg_write and mem_write never asserted.
REQ-047 rst_n dropped during MEM_WR with mem_ready=0 -> mem_write falls immediately; RST_WAIT then FETCH.
REQ-048 R-type then j back-to-back -> alu_op=10 in R_EXEC, reg_dst=1 in R_WB, pc_source=10 with pc_en=1 in JUMP; 7 cycles total.
